usb_bit_timer: RTL and testbench



---
 rtl/usb_timer_pkg.sv | 15 +
 rtl/timer_phase_counter.sv | 41 ++++
 rtl/usb_bit_timer.sv | 111 +++++++++++
 tb/tb_usb_bit_timer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_timer_pkg.sv
// Shared types and sizing helper for the USB bit-slot timer.
package usb_timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } timer_state_t;

   // Width needed to hold values 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/timer_phase_counter.sv
// Bit-slot phase counter: runs 1..CLKS_PER_BIT and wraps back to 1; 0 means stopped.
module timer_phase_counter
   import usb_timer_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 5,
   parameter int unsigned PW           = cnt_width(CLKS_PER_BIT + 1)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          clear,
   input  logic          enable,
   input  logic          load_one,
   output logic [PW-1:0] phase
);

   logic [PW-1:0] phase_q;
   logic [PW-1:0] phase_d;

   // Clear wins over load so a dropped run request always parks at 0.
   always_comb begin
      phase_d = phase_q;
      if (clear) begin
         phase_d = '0;
      end else if (load_one) begin
         phase_d = PW'(1);
      end else if (enable) begin
         phase_d = (phase_q == PW'(CLKS_PER_BIT)) ? PW'(1) : phase_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/usb_bit_timer.sv
// Bit-slot timer: per-bit shift strobe, stuffed-slot strobe and end-of-byte strobe.
//
// state | meaning
// IDLE  | stopped, phase and bit count at 0
// RUN   | counting bit slots, strobes active
// HOLD  | one-shot byte finished, frozen until the run request drops
module usb_bit_timer
   import usb_timer_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT  = 5,
   parameter int unsigned SHIFT_PHASE   = 1,
   parameter int unsigned BITS_PER_BYTE = 8
) (
   input  logic                                clk,
   input  logic                                n_rst,
   input  logic                                enable_timer,
   input  logic                                oneshot,
   input  logic                                stuff_req,
   input  logic                                resync,
   output logic                                shift_enable,
   output logic                                stuff_slot,
   output logic                                byte_sent,
   output logic [cnt_width(BITS_PER_BYTE)-1:0] bit_index,
   output logic                                busy
);

   localparam int unsigned PW = cnt_width(CLKS_PER_BIT + 1);
   localparam int unsigned BW = cnt_width(BITS_PER_BYTE);
   localparam logic [BW-1:0] LAST_BIT = BW'(BITS_PER_BYTE - 1);

   timer_state_t  state_q, state_d;
   logic          oneshot_q, oneshot_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [PW-1:0] phase;
   logic          ph_clear, ph_enable, ph_load;
   logic          tick;

   timer_phase_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .PW           (PW)
   ) u_phase (
      .clk      (clk),
      .n_rst    (n_rst),
      .clear    (ph_clear),
      .enable   (ph_enable),
      .load_one (ph_load),
      .phase    (phase)
   );

   // Strobes come from the current phase, so a same-cycle resync or a
   // falling run request never swallows the slot that is already due.
   assign tick         = (state_q == RUN) && (phase == PW'(SHIFT_PHASE));
   assign shift_enable = tick && !stuff_req;
   assign stuff_slot   = tick && stuff_req;
   assign byte_sent    = shift_enable && (bit_cnt_q == LAST_BIT);
   assign bit_index    = bit_cnt_q;
   assign busy         = (state_q == RUN);

   always_comb begin
      state_d   = state_q;
      oneshot_d = oneshot_q;
      bit_cnt_d = bit_cnt_q;
      ph_clear  = 1'b0;
      ph_enable = 1'b0;
      ph_load   = 1'b0;

      case (state_q)
         IDLE: begin
            if (enable_timer) begin
               state_d   = RUN;
               oneshot_d = oneshot;
               ph_load   = 1'b1;
            end
         end
         RUN: begin
            ph_enable = 1'b1;
            ph_load   = resync;
            if (shift_enable) begin
               bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + BW'(1);
            end
            if (byte_sent && oneshot_q) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (!enable_timer) begin
         state_d   = IDLE;
         bit_cnt_d = '0;
         ph_clear  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= IDLE;
         oneshot_q <= 1'b0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         oneshot_q <= oneshot_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

endmodule

// File: tb/tb_usb_bit_timer.sv
// Bench for usb_bit_timer: default and (4,4,4) instances against a slot-arithmetic model.
module tb_usb_bit_timer;

   logic       clk = 1'b0;
   logic       n_rst = 1'b1;
   logic       enable_timer = 1'b0;
   logic       oneshot = 1'b0;
   logic       stuff_req = 1'b0;
   logic       resync = 1'b0;

   logic       se0, ss0, bs0, busy0;
   logic [2:0] bidx0;
   logic       se1, ss1, bs1, busy1;
   logic [1:0] bidx1;

   int n_checks = 0;
   int n_errs   = 0;
   bit started  = 1'b0;

   always #5 clk = ~clk;

   usb_bit_timer u_dut0 (
      .clk(clk), .n_rst(n_rst), .enable_timer(enable_timer), .oneshot(oneshot),
      .stuff_req(stuff_req), .resync(resync), .shift_enable(se0), .stuff_slot(ss0),
      .byte_sent(bs0), .bit_index(bidx0), .busy(busy0)
   );

   usb_bit_timer #(.CLKS_PER_BIT(4), .SHIFT_PHASE(4), .BITS_PER_BYTE(4)) u_dut1 (
      .clk(clk), .n_rst(n_rst), .enable_timer(enable_timer), .oneshot(oneshot),
      .stuff_req(stuff_req), .resync(resync), .shift_enable(se1), .stuff_slot(ss1),
      .byte_sent(bs1), .bit_index(bidx1), .busy(busy1)
   );

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errs++;
         $display("FAIL %s: got %0d, expected %0d at time %0t", name, got, exp, $time);
      end
   endtask

   // Model: a run is a sequence of slots of C clocks measured from the last
   // alignment point (start or resync); the tick lands at offset SP-1 of a slot.
   int cpb[2] = '{5, 4};
   int sph[2] = '{1, 4};
   int bpb[2] = '{8, 4};
   int mode[2];      // 0 stopped, 1 running, 2 held after a one-shot byte
   int since[2];     // clocks since the last alignment point
   int bits[2];      // data bits finished in the current byte
   bit once[2];

   initial begin
      for (int i = 0; i < 2; i++) begin
         mode[i] = 0; since[i] = 0; bits[i] = 0; once[i] = 1'b0;
      end
   end

   task automatic model_out(input int id, output bit e_se, output bit e_ss,
                            output bit e_bs, output bit e_busy, output int e_bidx);
      bit t;
      t      = (mode[id] == 1) && ((since[id] % cpb[id]) + 1 == sph[id]);
      e_se   = t && !stuff_req;
      e_ss   = t && stuff_req;
      e_bs   = e_se && (bits[id] == bpb[id] - 1);
      e_busy = (mode[id] == 1);
      e_bidx = bits[id];
   endtask

   always @(posedge clk or negedge n_rst) begin
      bit e_se, e_ss, e_bs, e_busy;
      int e_bidx;
      for (int id = 0; id < 2; id++) begin
         if (!n_rst || !enable_timer) begin
            mode[id] = 0; since[id] = 0; bits[id] = 0;
            if (!n_rst) once[id] = 1'b0;
         end else begin
            model_out(id, e_se, e_ss, e_bs, e_busy, e_bidx);
            if (mode[id] == 0) begin
               mode[id] = 1; since[id] = 0; once[id] = oneshot;
            end else if (mode[id] == 1) begin
               if (e_se) bits[id] = (bits[id] + 1) % bpb[id];
               since[id] = resync ? 0 : since[id] + 1;
               if (e_bs && once[id]) mode[id] = 2;
            end
         end
      end
   end

   always @(negedge clk) begin
      bit e_se, e_ss, e_bs, e_busy;
      int e_bidx;
      if (started) begin
         model_out(0, e_se, e_ss, e_bs, e_busy, e_bidx);
         chk("d0 shift_enable", se0, e_se);
         chk("d0 stuff_slot", ss0, e_ss);
         chk("d0 byte_sent", bs0, e_bs);
         chk("d0 busy", busy0, e_busy);
         chk("d0 bit_index", bidx0, e_bidx);
         model_out(1, e_se, e_ss, e_bs, e_busy, e_bidx);
         chk("d1 shift_enable", se1, e_se);
         chk("d1 stuff_slot", ss1, e_ss);
         chk("d1 byte_sent", bs1, e_bs);
         chk("d1 busy", busy1, e_busy);
         chk("d1 bit_index", bidx1, e_bidx);
      end
   end

   int first_bs0, first_bs1, bs_cnt0, se_cnt0, se_cnt1, ss_cnt0;
   int bidx36, bidx37, busy_last;
   int se_cyc0[$];

   // Reset, then raise the run request so that the next edge is E0; returns in cycle 1.
   task automatic start(input bit os);
      n_rst = 1'b0; enable_timer = 1'b0; stuff_req = 1'b0; resync = 1'b0; oneshot = os;
      @(posedge clk); #1;
      n_rst = 1'b1; enable_timer = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic run(input int n, input int stuff_at, input int resync_at);
      first_bs0 = 0; first_bs1 = 0; bs_cnt0 = 0; se_cnt0 = 0; se_cnt1 = 0; ss_cnt0 = 0;
      bidx36 = -1; bidx37 = -1; busy_last = -1;
      se_cyc0.delete();
      for (int k = 1; k <= n; k++) begin
         stuff_req = (k == stuff_at);
         resync    = (k == resync_at);
         @(negedge clk);
         if (se0) begin se_cnt0++; se_cyc0.push_back(k); end
         if (se1) se_cnt1++;
         if (ss0) ss_cnt0++;
         if (bs0) begin bs_cnt0++; if (first_bs0 == 0) first_bs0 = k; end
         if (bs1 && first_bs1 == 0) first_bs1 = k;
         if (k == 36) bidx36 = bidx0;
         if (k == 37) bidx37 = bidx0;
         busy_last = busy0;
         @(posedge clk); #1;
      end
      stuff_req = 1'b0; resync = 1'b0;
   endtask

   initial begin
      #2 n_rst = 1'b0;
      #1;
      started = 1'b1;
      chk("reset shift_enable", se0, 0);
      chk("reset busy", busy0, 0);
      chk("reset bit_index", bidx0, 0);
      @(posedge clk); #1;

      // Free-running byte on both instances.
      start(1'b0);
      run(40, 0, 0);
      chk("s1 first byte_sent cycle", first_bs0, 36);
      chk("s1 byte_sent count", bs_cnt0, 1);
      chk("s1 shift count", se_cnt0, 8);
      chk("s1 third tick cycle", se_cyc0.size() > 2 ? se_cyc0[2] : -1, 11);
      chk("s1 bit_index at 36", bidx36, 7);
      chk("s1 bit_index at 37", bidx37, 0);
      chk("s1 d1 first byte_sent cycle", first_bs1, 16);
      chk("s1 d1 shift count", se_cnt1, 10);

      // Stuffed third slot pushes the byte end out by one slot.
      start(1'b0);
      run(45, 11, 0);
      chk("s2 first byte_sent cycle", first_bs0, 41);
      chk("s2 stuff count", ss_cnt0, 1);
      chk("s2 shift count", se_cnt0, 8);

      // One-shot: single byte then hold, restart after the request drops.
      start(1'b1);
      run(90, 0, 0);
      chk("s3 first byte_sent cycle", first_bs0, 36);
      chk("s3 byte_sent count", bs_cnt0, 1);
      chk("s3 shift count", se_cnt0, 8);
      chk("s3 busy while held", busy_last, 0);
      enable_timer = 1'b0;
      @(posedge clk); #1;
      enable_timer = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("s3 restart first tick", se0, 1);
      @(posedge clk); #1;

      // Resync in cycle 3 pulls the next tick in to cycle 4.
      start(1'b0);
      run(10, 0, 3);
      chk("s4 first tick", se_cyc0.size() > 0 ? se_cyc0[0] : -1, 1);
      chk("s4 tick after resync", se_cyc0.size() > 1 ? se_cyc0[1] : -1, 4);
      chk("s4 following tick", se_cyc0.size() > 2 ? se_cyc0[2] : -1, 9);

      // Asynchronous reset mid-byte, then restart.
      start(1'b0);
      run(19, 0, 0);
      chk("s5 busy before reset", busy0, 1);
      #2 n_rst = 1'b0;
      #1;
      chk("s5 async busy", busy0, 0);
      chk("s5 async bit_index", bidx0, 0);
      chk("s5 async shift_enable", se0, 0);
      @(posedge clk); #1;
      n_rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("s5 first tick after release", se0, 1);
      chk("s5 busy after release", busy0, 1);
      @(posedge clk); #1;

      // Random traffic against the model.
      oneshot = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         enable_timer = ($urandom_range(0, 63) != 0);
         if (!enable_timer) oneshot = $urandom_range(0, 1);
         stuff_req = ($urandom_range(0, 7) == 0);
         resync    = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 499) == 0) begin
            n_rst = 1'b0;
            #2 n_rst = 1'b1;
         end
         @(posedge clk); #1;
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
